kyber_word_streamer: RTL and testbench

- Upstream feeder for Kyber_Wrapper. On a start pulse it reads a run of 32-bit words from the register-side key/input RAM (synchronous read, 1-cycle latency, 8-bit word address).
- Presents the words in order as a valid/ready stream to the core's load/din side.
- Provides busy/done status for the register block, and a trigger.
- Absorbs RAM read latency and core backpressure with a 2-entry buffer, so a ready-high core sees one word per cycle.

---
 rtl/kyber_stream_pkg.sv | 15 +
 rtl/kyber_skid_fifo.sv | 53 +++++
 rtl/kyber_word_streamer.sv | 108 ++++++++++
 tb/tb_kyber_word_streamer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/kyber_stream_pkg.sv
// rtl/kyber_stream_pkg.sv - shared widths, FIFO depth and FSM states for the Kyber word streamer.
package kyber_stream_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int CNT_W      = ADDR_W + 1;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kyber_skid_fifo.sv
// rtl/kyber_skid_fifo.sv - 2-entry FIFO absorbing RAM read latency and core backpressure.
module kyber_skid_fifo
  import kyber_stream_pkg::*;
#(
  parameter int pWIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [pWIDTH-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [pWIDTH-1:0] o_data,
  output logic [1:0]        o_count,
  output logic              o_empty
);

  logic [pWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // Reads are credit-limited upstream, so a push into a full FIFO without a pop is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !w_pop && !i_flush && (r_count == 2'(FIFO_DEPTH))));

endmodule

// File: rtl/kyber_word_streamer.sv
// rtl/kyber_word_streamer.sv - streams a run of RAM words to the Kyber core; KYBER_STREAM_BYTESWAP_EN byte-reverses output words.
module kyber_word_streamer
  import kyber_stream_pkg::*;
#(
  parameter int pDATA_WIDTH = DATA_W,
  parameter int pADDR_WIDTH = ADDR_W,
  parameter int pCNT_WIDTH  = CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [pCNT_WIDTH-1:0]  len_i,
  output logic [pADDR_WIDTH-1:0] mem_addr_o,
  output logic                   mem_rd_o,
  input  logic [pDATA_WIDTH-1:0] mem_rdata_i,
  output logic [pDATA_WIDTH-1:0] m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [pCNT_WIDTH-1:0]  word_cnt_o
);

  state_t                 r_state;
  logic [pCNT_WIDTH-1:0]  r_len;
  logic [pCNT_WIDTH-1:0]  r_issued;
  logic [pCNT_WIDTH-1:0]  r_accepted;
  logic [pADDR_WIDTH-1:0] r_addr_hold;
  logic                   r_inflight;

  logic                   w_rd;
  logic                   w_xfer;
  logic                   w_empty;
  logic [1:0]             w_count;
  logic [2:0]             w_credit;
  logic [pDATA_WIDTH-1:0] w_head;

  assign m_valid_o  = !w_empty;
  assign w_xfer     = m_valid_o && m_ready_i;
  assign w_credit   = {1'b0, w_count} + {2'b0, r_inflight};
  // A pop this cycle frees a slot, which keeps a ready-high core fed every cycle.
  assign w_rd       = (r_state == ST_RUN) && !abort_i && (r_issued < r_len) &&
                      (w_credit < (3'(FIFO_DEPTH) + {2'b0, w_xfer}));
  assign mem_rd_o   = w_rd;
  assign mem_addr_o = w_rd ? r_issued[pADDR_WIDTH-1:0] : r_addr_hold;
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = (r_state == ST_DONE);
  assign word_cnt_o = r_accepted;

  kyber_skid_fifo #(
    .pWIDTH (pDATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight && !abort_i),
    .i_data  (mem_rdata_i),
    .i_pop   (w_xfer),
    .i_flush (abort_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

`ifdef KYBER_STREAM_BYTESWAP_EN
  always_comb begin
    m_data_o = '0;
    for (int b = 0; b < pDATA_WIDTH / 8; b++)
      m_data_o[8*b +: 8] = w_head[pDATA_WIDTH-8-8*b +: 8];
  end
`else
  assign m_data_o = w_head;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_addr_hold <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd) begin
        r_issued    <= r_issued + 1'b1;
        r_addr_hold <= r_issued[pADDR_WIDTH-1:0];
      end
      if (w_xfer) r_accepted <= r_accepted + 1'b1;
      if (abort_i) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (start_i) begin
            r_len      <= len_i;
            r_issued   <= '0;
            r_accepted <= '0;
            r_state    <= (len_i == '0) ? ST_DONE : ST_RUN;
          end
          ST_RUN:  if (r_accepted == r_len) r_state <= ST_DONE;
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kyber_word_streamer.sv
// tb/tb_kyber_word_streamer.sv - scoreboard bench for kyber_word_streamer (honours KYBER_STREAM_BYTESWAP_EN).
module tb_kyber_word_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, m_ready_i;
  logic [8:0]  len_i;
  logic [7:0]  mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] m_data_o;
  logic        m_valid_o, busy_o, done_o;
  logic [8:0]  word_cnt_o;

  logic [31:0] ram [256];
  logic [31:0] sb [$];
  int errors = 0, checks = 0;
  int exp_addr = 0, rd_cnt = 0, xfer_cnt = 0;

  always #5 clk = ~clk;

  kyber_word_streamer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .len_i(len_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .done_o(done_o), .word_cnt_o(word_cnt_o)
  );

  always @(posedge clk) if (mem_rd_o) mem_rdata_i <= ram[mem_addr_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef KYBER_STREAM_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (m_valid_o && m_ready_i) begin
      xfer_cnt++;
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("data", m_data_o, sb.pop_front());
    end
    if (mem_rd_o) begin
      rd_cnt++;
      check("addr", {24'd0, mem_addr_o}, exp_addr);
      exp_addr++;
    end
  end

  task automatic start_run(input int len);
    for (int i = 0; i < len; i++) sb.push_back(exp_word(ram[i]));
    exp_addr = 0;
    start_i  = 1'b1;
    len_i    = len[8:0];
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic observe(input int max, input bit rnd,
                         output int fv, output int dc, output int nd, output int nb);
    fv = -1; dc = -1; nd = 0; nb = 0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (m_valid_o && fv < 0) fv = c;
      if (busy_o) nb++;
      if (done_o) begin
        nd++;
        if (dc < 0) dc = c;
      end
      @(posedge clk); #1;
      if (rnd) m_ready_i = 1'($urandom_range(0, 1));
      if (dc >= 0 && c >= dc + 2) break;
    end
  endtask

  initial begin
    int fv, dc, nd, nb, rd0;
    bit hit;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; m_ready_i = 1'b0; len_i = '0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + i;
    repeat (3) @(posedge clk); #1;
    check("reset_outs", {23'd0, mem_addr_o, mem_rd_o, m_valid_o, busy_o, done_o, word_cnt_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: len=8, ready held high
    m_ready_i = 1'b1; xfer_cnt = 0;
    start_run(8);
    observe(40, 1'b0, fv, dc, nd, nb);
    check("t1_first_valid", fv, 2);
    check("t1_done_cycle", dc, 11);
    check("t1_done_count", nd, 1);
    check("t1_busy_cycles", nb, 12);
    check("t1_word_cnt", {23'd0, word_cnt_o}, 8);
    check("t1_sb_empty", sb.size(), 0);

    // 2: len=256 with random backpressure
    m_ready_i = 1'($urandom_range(0, 1)); xfer_cnt = 0; rd0 = rd_cnt;
    start_run(256);
    observe(2000, 1'b1, fv, dc, nd, nb);
    check("t2_done_seen", dc >= 0, 1);
    check("t2_done_count", nd, 1);
    check("t2_word_cnt", {23'd0, word_cnt_o}, 256);
    check("t2_reads", rd_cnt - rd0, 256);
    check("t2_xfers", xfer_cnt, 256);
    check("t2_sb_empty", sb.size(), 0);

    // 3: zero-length run
    m_ready_i = 1'b1; rd0 = rd_cnt;
    start_run(0);
    observe(10, 1'b0, fv, dc, nd, nb);
    check("t3_no_reads", rd_cnt - rd0, 0);
    check("t3_done_cycle", dc, 0);
    check("t3_busy_cycles", nb, 1);
    check("t3_word_cnt", {23'd0, word_cnt_o}, 0);

    // 4: abort after 5 transfers, then a fresh len=4 run
    xfer_cnt = 0; hit = 1'b0;
    start_run(16);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt == 5) hit = 1'b1;
    end
    check("t4_reach_5", hit, 1);
    @(posedge clk); #1;
    m_ready_i = 1'b0; abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    @(negedge clk);
    check("t4_valid_low", m_valid_o, 0);
    check("t4_idle", busy_o, 0);
    check("t4_word_cnt", {23'd0, word_cnt_o}, 5);
    @(posedge clk); #1;
    observe(4, 1'b0, fv, dc, nd, nb);
    check("t4_no_done", nd, 0);
    sb.delete();
    m_ready_i = 1'b1;
    start_run(4);
    observe(20, 1'b0, fv, dc, nd, nb);
    check("t4_rerun_done", nd, 1);
    check("t4_rerun_cnt", {23'd0, word_cnt_o}, 4);
    check("t4_sb_empty", sb.size(), 0);

    // 5: second start mid-run ignored, then async reset mid-run
    start_run(8);
    repeat (3) @(posedge clk); #1;
    start_i = 1'b1; len_i = 9'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    observe(30, 1'b0, fv, dc, nd, nb);
    check("t5_done_count", nd, 1);
    check("t5_word_cnt", {23'd0, word_cnt_o}, 8);
    check("t5_sb_empty", sb.size(), 0);
    start_run(8);
    repeat (4) @(posedge clk); #3;
    rst_n = 1'b0; #1;
    check("t5_rst_outs", {23'd0, mem_addr_o, mem_rd_o, m_valid_o, busy_o, done_o, word_cnt_o}, 32'd0);
    check("t5_rst_data", m_data_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    repeat (5) @(posedge clk); #1;
    check("t5_stays_idle", busy_o, 0);

    // 6: byte order of the output word
    m_ready_i = 1'b0;
    ram[0] = 32'h1122_3344;
    start_run(1);
    repeat (4) @(posedge clk); #1;
    check("t6_valid", m_valid_o, 1);
`ifdef KYBER_STREAM_BYTESWAP_EN
    check("t6_swap", m_data_o, 32'h4433_2211);
`else
    check("t6_swap", m_data_o, 32'h1122_3344);
`endif
    m_ready_i = 1'b1;
    observe(10, 1'b0, fv, dc, nd, nb);
    check("t6_done", nd, 1);
    check("t6_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
